carry_select_subtractor_pipe: RTL and testbench

//  16-bit pipelined carry-select subtractor: diff = a - b, plus borrow-out and signed overflow.

---
 rtl/carry_select_subtractor_pipe.sv | 112 +++++++++++
 tb/tb_carry_select_subtractor_pipe.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/carry_select_subtractor_pipe.sv
// Two-stage carry-select subtractor: diff = a - b with borrow-out and signed overflow.
// Latency: operand accepted on edge N, result valid after edge N+1 (two register stages).
// Backpressure: a stalled output holds both stages; only out_ready reaches in_ready combinationally.
module carry_select_subtractor_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  // Each candidate carries its segment carry-out in the MSB.
  typedef struct packed {
    logic [2:0] seg0;
    logic [2:0] seg1_c0;
    logic [2:0] seg1_c1;
    logic [3:0] seg2_c0;
    logic [3:0] seg2_c1;
    logic [4:0] seg3_c0;
    logic [4:0] seg3_c1;
    logic [5:0] seg4_c0;
    logic [5:0] seg4_c1;
    logic       a_msb;
    logic       b_msb;
  } s1_t;

  logic [WIDTH-1:0] b_n;
  s1_t              s1_nxt;
  s1_t              s1_q;
  logic             s1_valid;
  logic             s2_valid;
  logic             s2_adv;
  logic             in_fire;

  logic             c0, c1, c2, c3, c4;
  logic [WIDTH-1:0] d_sel;
  logic             borrow_nxt;
  logic             ovf_nxt;

  assign b_n       = ~b;
  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !reset && (!s1_valid || s2_adv);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;

  // Stage 1: a + ~b per segment, both carry-in hypotheses for the upper ones.
  always_comb begin
    s1_nxt         = '0;
    s1_nxt.seg0    = {1'b0, a[1:0]}   + {1'b0, b_n[1:0]}   + 3'd1;
    s1_nxt.seg1_c0 = {1'b0, a[3:2]}   + {1'b0, b_n[3:2]};
    s1_nxt.seg1_c1 = {1'b0, a[3:2]}   + {1'b0, b_n[3:2]}   + 3'd1;
    s1_nxt.seg2_c0 = {1'b0, a[6:4]}   + {1'b0, b_n[6:4]};
    s1_nxt.seg2_c1 = {1'b0, a[6:4]}   + {1'b0, b_n[6:4]}   + 4'd1;
    s1_nxt.seg3_c0 = {1'b0, a[10:7]}  + {1'b0, b_n[10:7]};
    s1_nxt.seg3_c1 = {1'b0, a[10:7]}  + {1'b0, b_n[10:7]}  + 5'd1;
    s1_nxt.seg4_c0 = {1'b0, a[15:11]} + {1'b0, b_n[15:11]};
    s1_nxt.seg4_c1 = {1'b0, a[15:11]} + {1'b0, b_n[15:11]} + 6'd1;
    s1_nxt.a_msb   = a[15];
    s1_nxt.b_msb   = b[15];
  end

  // Stage 2: ripple the select chain across the precomputed candidates.
  always_comb begin
    d_sel              = '0;
    c0                 = s1_q.seg0[2];
    d_sel[1:0]         = s1_q.seg0[1:0];
    {c1, d_sel[3:2]}   = c0 ? s1_q.seg1_c1 : s1_q.seg1_c0;
    {c2, d_sel[6:4]}   = c1 ? s1_q.seg2_c1 : s1_q.seg2_c0;
    {c3, d_sel[10:7]}  = c2 ? s1_q.seg3_c1 : s1_q.seg3_c0;
    {c4, d_sel[15:11]} = c3 ? s1_q.seg4_c1 : s1_q.seg4_c0;
    borrow_nxt         = !c4;
    ovf_nxt            = (s1_q.a_msb != s1_q.b_msb) && (d_sel[15] != s1_q.a_msb);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          diff   <= d_sel;
          borrow <= borrow_nxt;
          ovf    <= ovf_nxt;
        end
      end
      if (in_fire)
        s1_valid <= 1'b1;
      else if (s2_adv)
        s1_valid <= 1'b0;
    end
  end

  // Candidate payload is qualified by s1_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (in_fire)
      s1_q <= s1_nxt;
  end

endmodule

// File: tb/tb_carry_select_subtractor_pipe.sv
// Directed and random checks of carry_select_subtractor_pipe against a - b, a < b and the signed-overflow rule.
module tb_carry_select_subtractor_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  carry_select_subtractor_pipe #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Single transaction with out_ready high: result must appear one edge after the accept edge.
  task automatic run_one(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] ed, input logic eb, input logic eo);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk({tag, "_early"}, out_valid, 0);
    tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_borrow"}, borrow, eb);
    chk({tag, "_ovf"}, ovf, eo);
  endtask

  logic [17:0] sb[$];
  logic [17:0] exp_e;
  logic [15:0] ra, rb, md;
  int          acc;
  int          stale;
  int          unstable;
  int          cyc;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    tick(); tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_ovf", ovf, 0);
    reset = 1'b0;

    run_one("basic",  16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
    run_one("ripple", 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
    run_one("ovf_neg",16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    run_one("ovf_pos",16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);
    run_one("seg2_3", 16'h0080, 16'h0001, 16'h007F, 1'b0, 1'b0);
    run_one("seg3_4", 16'h0800, 16'h0001, 16'h07FF, 1'b0, 1'b0);
    run_one("seg1_2", 16'h0010, 16'h0011, 16'hFFFF, 1'b1, 1'b0);
    tick();
    chk("drain_idle", out_valid, 0);

    // Backpressure: three pairs offered for six stalled cycles.
    out_ready = 1'b0; acc = 0; unstable = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      case (acc)
        0: begin a = 16'h1234; b = 16'h0234; end
        1: begin a = 16'h0100; b = 16'h0200; end
        default: begin a = 16'hA000; b = 16'h2000; end
      endcase
      #1;
      if (out_valid && (diff !== 16'h1000 || borrow !== 1'b0)) unstable++;
      if (in_ready) acc++;
      tick();
    end
    #1;
    chk("bp_accepted", acc, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head_diff", diff, 16'h1000);
    chk("bp_stable", unstable, 0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_r1_valid", out_valid, 1);
    chk("bp_r1_diff", diff, 16'hFF00);
    chk("bp_r1_borrow", borrow, 1);
    tick();
    chk("bp_r2_valid", out_valid, 1);
    chk("bp_r2_diff", diff, 16'h8000);
    chk("bp_r2_borrow", borrow, 0);
    chk("bp_r2_ovf", ovf, 0);
    tick();
    chk("bp_empty", out_valid, 0);

    // Reset with two operands in flight.
    out_ready = 1'b0; in_valid = 1'b1;
    a = 16'h0003; b = 16'h0001;
    tick();
    a = 16'h0009; b = 16'h0004;
    tick();
    in_valid = 1'b0;
    chk("rf_loaded", out_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rf_out_valid", out_valid, 0);
    chk("rf_diff", diff, 0);
    chk("rf_borrow", borrow, 0);
    chk("rf_in_ready", in_ready, 1);
    out_ready = 1'b1; stale = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid) stale++;
    end
    chk("rf_no_stale", stale, 0);
    run_one("rf_next", 16'h4321, 16'h1234, 16'h30ED, 1'b0, 1'b0);
    tick();

    // Random streaming with a scoreboard.
    acc = 0; cyc = 0;
    while ((acc < 10000 || sb.size() != 0) && cyc < 60000) begin
      in_valid  = (acc < 10000) && ($urandom_range(0, 3) != 0);
      ra = 16'($urandom); rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      a = ra; b = rb;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("rnd_underflow", 1, 0);
        end else begin
          exp_e = sb.pop_front();
          chk("rnd_result", {14'd0, borrow, ovf, diff}, {14'd0, exp_e});
        end
      end
      if (in_valid && in_ready) begin
        md = ra - rb;
        sb.push_back({(ra < rb), ((ra[15] != rb[15]) && (md[15] != ra[15])), md});
        acc++;
      end
      tick();
      cyc++;
    end
    chk("rnd_done", (acc == 10000 && sb.size() == 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
